// File: rtl/bram_frame_streamer.sv
// Sequential frame reader for a single-port pixel BRAM, producing a valid/ready pixel stream with sof/eol/last markers.
// Latency: first m_valid appears RD_LAT+2 cycles after the start pulse; 1 pixel/cycle sustained while m_ready stays high.
// Backpressure: reads are issued only while the output FIFO plus in-flight reads fit in RD_LAT+1 entries, so m_ready low throttles ena.
//
// Ports:
//   clka, rsta_n               clock (rising edge), asynchronous active-low reset
//   start, continuous, stop    control: start a frame (continuous sampled with start), stop at end of current frame
//   busy, done, frame_cnt      status: not idle, 1-cycle end-of-run pulse, completed-frame counter
//   ena, addra, douta          BRAM read port (write enable is tied off outside this block)
//   m_valid/m_ready/m_data     pixel stream, with m_sof/m_eol/m_last markers

module bram_frame_streamer #(
   parameter int DATA_W = 24,
   parameter int ADDR_W = 15,
   parameter int IMG_W  = 160,
   parameter int IMG_H  = 115,
   parameter int RD_LAT = 1
) (
   input  logic              clka,
   input  logic              rsta_n,
   input  logic              start,
   input  logic              continuous,
   input  logic              stop,
   output logic              busy,
   output logic              done,
   output logic [15:0]       frame_cnt,
   output logic              ena,
   output logic [ADDR_W-1:0] addra,
   input  logic [DATA_W-1:0] douta,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_sof,
   output logic              m_eol,
   output logic              m_last
);

   localparam int FIFO_DEPTH = RD_LAT + 1;
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int COL_W      = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W      = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);
   localparam logic [CNT_W:0]   DEPTH_V  = (CNT_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Marker tags travelling alongside the BRAM read latency.
   typedef struct packed {
      logic vld;
      logic sof;
      logic eol;
      logic last;
   } tag_t;

   typedef struct packed {
      logic [DATA_W-1:0] dat;
      logic              sof;
      logic              eol;
      logic              last;
   } beat_t;

   state_t              state_q, state_d;
   logic                cont_q, cont_d;
   logic                stop_q, stop_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [COL_W-1:0]    col_q, col_d;
   logic [ROW_W-1:0]    row_q, row_d;
   logic                done_q, done_d;
   logic [15:0]         frame_cnt_q, frame_cnt_d;

   tag_t                tag_q [RD_LAT];
   tag_t                tag_d [RD_LAT];

   beat_t               fifo_q [FIFO_DEPTH];
   beat_t               fifo_d [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic [CNT_W-1:0]    inflight;
   logic                credit_ok;
   logic                issue;
   logic                pop;
   logic                push;
   logic                cur_sof;
   logic                cur_eol;
   logic                cur_last;
   logic                last_beat_acc;
   tag_t                tag_exit;
   beat_t               head;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // ---------------------------------------------------------------------
   // Credit, issue and marker decode
   // ---------------------------------------------------------------------
   assign head          = fifo_q[rd_ptr_q];
   assign tag_exit      = tag_q[RD_LAT-1];
   assign push          = tag_exit.vld;
   assign pop           = (cnt_q != '0) && m_ready;
   assign last_beat_acc = pop && head.last;

   assign cur_sof  = (addr_q == '0);
   assign cur_eol  = (col_q == LAST_COL);
   assign cur_last = cur_eol && (row_q == LAST_ROW);

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         inflight = inflight + {{(CNT_W-1){1'b0}}, tag_q[i].vld};
      end
   end

   // The beat leaving the FIFO this cycle returns its slot immediately;
   // without that, a full-rate stream would stall every RD_LAT+1 cycles.
   assign credit_ok = ({1'b0, cnt_q} + {1'b0, inflight}) < (DEPTH_V + {{CNT_W{1'b0}}, pop});
   assign issue     = (state_q == RUN) && credit_ok;

   // ---------------------------------------------------------------------
   // Frame FSM and address/column/row counters
   // ---------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      cont_d      = cont_q;
      stop_d      = stop_q;
      addr_d      = addr_q;
      col_d       = col_q;
      row_d       = row_q;
      done_d      = 1'b0;
      frame_cnt_d = frame_cnt_q;

      if (last_beat_acc) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
      end

      unique case (state_q)
         IDLE: begin
            // stop arriving with start (or alone) is dropped here.
            stop_d = 1'b0;
            if (start) begin
               state_d = RUN;
               cont_d  = continuous;
               addr_d  = '0;
               col_d   = '0;
               row_d   = '0;
            end
         end
         RUN: begin
            stop_d = stop_q || stop;
            if (issue) begin
               if (cur_last) begin
                  addr_d = '0;
                  col_d  = '0;
                  row_d  = '0;
                  // Continuous mode rolls straight into the next frame with
                  // no bubble; otherwise wait for the last beat to drain.
                  if (!(cont_q && !(stop_q || stop))) begin
                     state_d = DRAIN;
                  end
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
                  if (cur_eol) begin
                     col_d = '0;
                     row_d = row_q + ROW_W'(1);
                  end else begin
                     col_d = col_q + COL_W'(1);
                  end
               end
            end
         end
         DRAIN: begin
            stop_d = stop_q || stop;
            // Only the final frame's beats can be outstanding here, as a
            // frame is longer than the FIFO plus read pipeline.
            if (last_beat_acc) begin
               state_d = IDLE;
               stop_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Read-latency tag pipe and output FIFO
   // ---------------------------------------------------------------------
   always_comb begin
      tag_d[0].vld  = issue;
      tag_d[0].sof  = issue && cur_sof;
      tag_d[0].eol  = issue && cur_eol;
      tag_d[0].last = issue && cur_last;
      for (int i = 1; i < RD_LAT; i++) begin
         tag_d[i] = tag_q[i-1];
      end
   end

   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;

      // douta is aligned with the tag leaving the last pipe stage.
      if (push) begin
         fifo_d[wr_ptr_q] = '{dat: douta, sof: tag_exit.sof, eol: tag_exit.eol, last: tag_exit.last};
         wr_ptr_d         = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end

      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         state_q     <= IDLE;
         cont_q      <= 1'b0;
         stop_q      <= 1'b0;
         addr_q      <= '0;
         col_q       <= '0;
         row_q       <= '0;
         done_q      <= 1'b0;
         frame_cnt_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            tag_q[i] <= '0;
         end
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cont_q      <= cont_d;
         stop_q      <= stop_d;
         addr_q      <= addr_d;
         col_q       <= col_d;
         row_q       <= row_d;
         done_q      <= done_d;
         frame_cnt_q <= frame_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         tag_q       <= tag_d;
         fifo_q      <= fifo_d;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs: stream is presented straight from the registered FIFO head
   // ---------------------------------------------------------------------
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign frame_cnt = frame_cnt_q;
   assign ena       = issue;
   assign addra     = addr_q;
   assign m_valid   = (cnt_q != '0);
   assign m_data    = head.dat;
   assign m_sof     = m_valid && head.sof;
   assign m_eol     = m_valid && head.eol;
   assign m_last    = m_valid && head.last;

endmodule

// File: tb/tb_bram_frame_streamer.sv
// Directed bench for bram_frame_streamer on a reduced 8x4 image with a 2-cycle BRAM.
// Latency: checks first m_valid at start+RD_LAT+2 and full-rate streaming with m_ready high.
// Backpressure: random m_ready phase checks stall stability and the read-credit bound.

module tb_bram_frame_streamer;

   localparam int DW = 24;
   localparam int AW = 15;
   localparam int W  = 8;
   localparam int H  = 4;
   localparam int N  = W * H;
   localparam int L  = 2;

   logic          clka       = 1'b0;
   logic          rsta_n     = 1'b1;
   logic          start      = 1'b0;
   logic          continuous = 1'b0;
   logic          stop       = 1'b0;
   logic          m_ready    = 1'b0;
   logic          busy;
   logic          done;
   logic [15:0]   frame_cnt;
   logic          ena;
   logic [AW-1:0] addra;
   logic [DW-1:0] douta;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_sof;
   logic          m_eol;
   logic          m_last;

   logic [DW-1:0] bram_pipe [L];

   int checks = 0;
   int errors = 0;
   int fc_exp = 0;

   always #5 clka = ~clka;

   function automatic logic [DW-1:0] pix(input int a);
      return DW'((a * 32'h0001_0203) ^ 32'h00A5_C3F0);
   endfunction

   // BRAM model: registered read, then L-1 further output stages.
   always @(posedge clka) begin
      if (ena) bram_pipe[0] <= pix(int'(addra));
      for (int i = 1; i < L; i++) bram_pipe[i] <= bram_pipe[i-1];
   end
   assign douta = bram_pipe[L-1];

   bram_frame_streamer #(
      .DATA_W (DW),
      .ADDR_W (AW),
      .IMG_W  (W),
      .IMG_H  (H),
      .RD_LAT (L)
   ) dut (
      .clka       (clka),
      .rsta_n     (rsta_n),
      .start      (start),
      .continuous (continuous),
      .stop       (stop),
      .busy       (busy),
      .done       (done),
      .frame_cnt  (frame_cnt),
      .ena        (ena),
      .addra      (addra),
      .douta      (douta),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_sof      (m_sof),
      .m_eol      (m_eol),
      .m_last     (m_last)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs one start..done sequence. Start is pulsed in loop cycle 0.
   task automatic run(input logic cont, input logic stop_first, input logic rnd,
                      input int stop_beat, input int start_beat, input int abort_beat,
                      input int exp_frames);
      int beats = 0, issued = 0, dones = 0, first_v = -1, last_c = -1, max_out = 0;
      int bad_addr = 0, bad_beat = 0, bad_stable = 0, bad_fc = 0, bad_busy = 0, bad_done = 0, quiet = 0;
      int budget = ((exp_frames > 0) ? exp_frames : 1) * N * 4 + 40;
      int idx, outst;
      bit stop_sent = 0, start_sent = 0, done_seen = 0, aborted = 0, prev_last = 0, held = 0, pop;
      logic [DW+2:0] held_v = '0;
      for (int c = 0; c < budget && !done_seen && !aborted; c++) begin
         @(negedge clka);
         start      = (c == 0);
         stop       = (c == 0) && stop_first;
         continuous = (c == 0) ? cont : ~cont;
         if (!start_sent && start_beat >= 0 && beats >= start_beat) begin start = 1'b1; start_sent = 1; end
         if (!stop_sent && stop_beat >= 0 && beats >= stop_beat) begin stop = 1'b1; stop_sent = 1; end
         m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         pop   = m_valid && m_ready;
         outst = issued + int'(ena) - beats - int'(pop);
         if (outst > max_out) max_out = outst;
         if (ena) begin
            if (int'(addra) != issued % N) bad_addr++;
            issued++;
         end
         if (held && (!m_valid || {m_data, m_sof, m_eol, m_last} !== held_v)) bad_stable++;
         if (m_valid && first_v < 0) first_v = c;
         if (frame_cnt !== 16'(fc_exp)) bad_fc++;
         if (c >= 1 && !done && !busy) bad_busy++;
         if (done) begin
            dones++;
            done_seen = 1;
            if (!prev_last || busy) bad_done++;
         end
         prev_last = 0;
         if (pop) begin
            idx = beats % N;
            if ({m_data, m_sof, m_eol, m_last} !== {pix(idx), idx == 0, idx % W == W - 1, idx == N - 1})
               bad_beat++;
            if (m_last) fc_exp = (fc_exp + 1) % 65536;
            prev_last = m_last;
            last_c    = c;
            beats++;
         end
         held   = m_valid && !m_ready;
         held_v = {m_data, m_sof, m_eol, m_last};
         if (abort_beat >= 0 && beats >= abort_beat) aborted = 1;
      end
      start = 1'b0;
      stop  = 1'b0;
      chk("credit_bound", max_out <= L + 1, 1'b1);
      chk("addr_sequence", bad_addr, 0);
      chk("beat_data_markers", bad_beat, 0);
      chk("stall_stable", bad_stable, 0);
      chk("frame_cnt_track", bad_fc, 0);
      chk("busy_while_running", bad_busy, 0);
      chk("first_valid_latency", first_v, L + 2);
      if (!aborted) begin
         chk("done_once", dones, 1);
         chk("done_after_last_beat", bad_done, 0);
         chk("beat_total", beats, exp_frames * N);
         if (!rnd) chk("full_rate_no_bubble", last_c - first_v + 1, beats);
         repeat (6) begin
            @(negedge clka);
            #1;
            if (ena || m_valid || busy || done) quiet++;
         end
         chk("quiet_after_done", quiet, 0);
      end
   endtask

   initial begin
      // Reset values
      #1 rsta_n = 1'b0;
      #2;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_ena", ena, 1'b0);
      chk("rst_addra", addra, 0);
      chk("rst_m_valid", m_valid, 1'b0);
      chk("rst_m_data", m_data, 0);
      chk("rst_markers", {m_sof, m_eol, m_last}, 3'b000);
      chk("rst_frame_cnt", frame_cnt, 0);
      @(negedge clka);
      rsta_n = 1'b1;

      // stop while idle does nothing
      @(negedge clka);
      stop = 1'b1;
      @(negedge clka);
      stop = 1'b0;
      repeat (3) @(negedge clka);
      #1;
      chk("idle_stop_ignored", {busy, ena}, 2'b00);

      // One-shot frame, m_ready held high
      run(1'b0, 1'b0, 1'b0, -1, -1, -1, 1);
      chk("frame_cnt_after_oneshot", frame_cnt, 1);

      // One-shot, random backpressure, extra start mid-frame must be ignored
      run(1'b0, 1'b0, 1'b1, -1, 10, -1, 1);
      chk("frame_cnt_after_stalled", frame_cnt, 2);

      // Continuous: stop with start is dropped, stop mid frame 2 ends after frame 2
      run(1'b1, 1'b1, 1'b0, N + N / 2, -1, -1, 2);
      chk("frame_cnt_after_continuous", frame_cnt, 4);

      // Reset mid-frame, then a clean restart from address 0
      run(1'b0, 1'b0, 1'b0, -1, -1, 13, 1);
      chk("busy_before_reset", busy, 1'b1);
      #2 rsta_n = 1'b0;
      #1;
      chk("async_reset_outputs",
          {busy, done, ena, m_valid, m_sof, m_eol, m_last, addra, m_data, frame_cnt}, 0);
      @(negedge clka);
      rsta_n = 1'b1;
      fc_exp = 0;
      @(negedge clka);
      run(1'b0, 1'b0, 1'b0, -1, -1, -1, 1);
      chk("frame_cnt_after_restart", frame_cnt, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
